// File: rtl/int8_dot_accumulator_if.sv
// ============================================================================
// int8_dot_accumulator_if
// Operand-in / result-out handshake bundle for int8_dot_accumulator.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface int8_dot_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     in_last;
  logic                     clear;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]         out_count;
  logic                     out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, clear, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, clear, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/int8_dot_accumulator.sv
// ============================================================================
// int8_dot_accumulator
// Streaming signed int8 x int8 dot-product accumulator with held result.
// Optional macro ACC_SATURATE_EN: clamp on overflow instead of wrapping.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module int8_dot_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 6
) (
  input  wire                  clk,
  input  wire                  rst,
  int8_dot_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t r_state;
  state_t w_state_nxt;

  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic                     r_ovf;
  logic                     r_out_valid;
  logic signed [ACC_W-1:0]  r_out_acc;
  logic [CNT_W-1:0]         r_out_count;
  logic                     r_out_ovf;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_clear;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W:0]    w_prod_ext;
  logic signed [ACC_W:0]    w_acc_ext;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_ovf;
  logic signed [ACC_W-1:0]  w_stored;
  logic [CNT_W-1:0]         w_cnt_inc;

  assign w_in_ready = (r_state != HOLD);
  assign w_clear    = w_in_ready & bus.clear;
  assign w_accept   = bus.in_valid & w_in_ready & ~bus.clear;

  // One guard bit above ACC_W exposes overflow as a sign disagreement.
  assign w_prod     = bus.in_a * bus.in_b;
  assign w_prod_ext = {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
  assign w_sum      = w_acc_ext + w_prod_ext;
  assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_cnt_inc  = (r_count == c_cnt_max) ? r_count : r_count + 1'b1;

`ifdef ACC_SATURATE_EN
  always_comb begin
    w_stored = w_sum[ACC_W-1:0];
    if (w_ovf) begin
      w_stored = w_sum[ACC_W] ? c_acc_min : c_acc_max;
    end
  end
`else
  assign w_stored = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_clear) begin
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_state_nxt = bus.in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_in_ready) begin
      if (w_clear) begin
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        if (bus.in_last) begin
          r_out_acc   <= w_stored;
          r_out_count <= w_cnt_inc;
          r_out_ovf   <= r_ovf | w_ovf;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_count     <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc   <= w_stored;
          r_count <= w_cnt_inc;
          r_ovf   <= r_ovf | w_ovf;
        end
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_int8_dot_accumulator.sv
// ============================================================================
// tb_int8_dot_accumulator
// Scoreboard bench for int8_dot_accumulator (honours ACC_SATURATE_EN).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int8_dot_accumulator;

  localparam int c_max = 524287;
  localparam int c_min = -524288;

  logic clk;
  logic rst;

  int8_dot_accumulator_if #(.DATA_W(8), .ACC_W(20), .CNT_W(6)) bus ();

  int8_dot_accumulator #(.DATA_W(8), .ACC_W(20), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc  = 0;
  int   m_cnt  = 0;
  int   m_ovf  = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_accept(input int a, input int b, input bit last);
    int   sum;
    int   st;
    exp_t e;
    sum = m_acc + a * b;
`ifdef ACC_SATURATE_EN
    st = (sum > c_max) ? c_max : (sum < c_min) ? c_min : sum;
`else
    st = (sum <<< 12) >>> 12;
`endif
    if (sum > c_max || sum < c_min) m_ovf = 1;
    m_cnt = (m_cnt == 63) ? 63 : m_cnt + 1;
    m_acc = st;
    if (last) begin
      e.acc = st;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic send(input int a, input int b, input bit last);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a[7:0];
    bus.in_b     = b[7:0];
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !bus.clear) break;
      waited++;
      if (waited > 100) begin
        check("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    model_accept(a, b, last);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (last) check("latency_out_valid", int'(bus.out_valid), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    model_clear();
  endtask

  // Results are retired on the handshake edge; sampling at negedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_acc", int'(bus.out_acc), e.acc);
        check("sb_count", int'(bus.out_count), e.cnt);
        check("sb_ovf", int'(bus.out_ovf), e.ovf);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_acc", int'(bus.out_acc), 0);
    check("rst_out_count", int'(bus.out_count), 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0);

    // Basic three-term product
    bus.out_ready = 1'b1;
    send(3, 4, 0);
    send(-2, 5, 0);
    send(7, -1, 1);
    check("t1_acc", int'(bus.out_acc), -5);
    check("t1_count", int'(bus.out_count), 3);
    check("t1_ovf", int'(bus.out_ovf), 0);
    @(posedge clk); #1;
    check("t1_idle_valid", int'(bus.out_valid), 0);
    check("t1_idle_ready", int'(bus.in_ready), 1);

    // Single term, held under backpressure
    bus.out_ready = 1'b0;
    send(-128, -128, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_acc", int'(bus.out_acc), 16384);
      check("hold_count", int'(bus.out_count), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", int'(bus.out_valid), 0);

    // 32 maximal terms overflow on the last one
    for (int i = 0; i < 32; i++) send(-128, -128, i == 31);
`ifdef ACC_SATURATE_EN
    check("ovf32_acc", int'(bus.out_acc), 524287);
`else
    check("ovf32_acc", int'(bus.out_acc), -524288);
`endif
    check("ovf32_ovf", int'(bus.out_ovf), 1);
    check("ovf32_count", int'(bus.out_count), 32);
    @(posedge clk); #1;

    // Clear beats a simultaneously offered pair
    send(10, 10, 0);
    send(10, 10, 0);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'sd5;
    bus.in_b     = 8'sd5;
    bus.in_last  = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    send(1, 1, 1);
    check("clear_acc", int'(bus.out_acc), 1);
    check("clear_count", int'(bus.out_count), 1);
    @(posedge clk); #1;

    // Reset during accumulation
    for (int i = 0; i < 4; i++) send(i + 1, 7, 0);
    do_reset();
    send(2, 3, 1);
    check("rst_accum_acc", int'(bus.out_acc), 6);
    check("rst_accum_count", int'(bus.out_count), 1);
    @(posedge clk); #1;

    // Reset during hold
    bus.out_ready = 1'b0;
    send(1, 1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    sb.delete();
    model_clear();

    // Back-to-back with the next pair offered during HOLD
    send(3, 3, 1);
    fork
      send(4, 4, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("b2b_in_ready", int'(bus.in_ready), 0);
        end
        check("b2b_held_acc", int'(bus.out_acc), 9);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b_gap_valid", int'(bus.out_valid), 0);
      end
    join
    check("b2b_second_acc", int'(bus.out_acc), 16);
    @(posedge clk); #1;

    // Random dot products against the model
    for (int n = 0; n < 6; n++) begin
      int len;
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, k == len - 1);
      end
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
